// File: rtl/jtframe_rom_pkg.sv
// Shared types and helpers for the parametrised SDRAM ROM arbiter:
// FSM state, field widths and the tag / lane-select arithmetic used by every slot.
package jtframe_rom_pkg;

    localparam int FIELD_W  = 8;
    localparam int OFFSET_W = 22;
    localparam int ADDR_W   = 22;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } rom_state_e;

    // Index of the 32-bit word holding addr; bits at or above aw are ignored.
    function automatic logic [ADDR_W-1:0] addr_tag(
        input logic [ADDR_W-1:0] addr,
        input int                aw,
        input int                dw
    );
        logic [ADDR_W-1:0] masked;
        masked = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            masked[b] = (b < aw) ? addr[b] : 1'b0;
        end
        case (dw)
            8:       addr_tag = masked >> 2;
            16:      addr_tag = masked >> 1;
            default: addr_tag = masked;
        endcase
    endfunction

    // Picks the byte / half-word / word addressed by the low address bits.
    function automatic logic [DATA_W-1:0] lane_sel(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        low,
        input int                dw
    );
        case (dw)
            8:       lane_sel = {24'd0, word[{low, 3'b000} +: 8]};
            16:      lane_sel = {16'd0, word[{low[0], 4'b0000} +: 16]};
            default: lane_sel = word;
        endcase
    endfunction

endpackage

// File: rtl/jtframe_rom_slot.sv
// One client slot: a single cached 32-bit word with its tag, plus the hit,
// miss and data-lane logic seen by the client.
module jtframe_rom_slot
    import jtframe_rom_pkg::*;
#(
    parameter int                  AW     = 18,
    parameter int                  DW     = 8,
    parameter logic [OFFSET_W-1:0] OFFSET = '0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ok,
    output logic              miss,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] fetch_tag,
    output logic [ADDR_W-1:0] fetch_addr
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hit;

    assign fetch_tag  = addr_tag(addr, AW, DW);
    // Word address in 16-bit SDRAM units, wrapping at 22 bits.
    assign fetch_addr = OFFSET + {fetch_tag[ADDR_W-2:0], 1'b0};

    assign hit  = cs & valid_q & (tag_q == fetch_tag) & ~flush;
    assign miss = cs & ~hit & ~flush;
    assign ok   = hit;
    assign dout = lane_sel(data_q, addr[1:0], DW);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (wr) begin
            valid_d = 1'b1;
            tag_d   = wr_tag;
            data_d  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/jtframe_rom_nslot.sv
// NSLOT-client ROM arbiter over one 32-bit SDRAM read port.
// Define JTFRAME_ROM_RR_EN for round-robin arbitration; otherwise lowest index wins.
module jtframe_rom_nslot
    import jtframe_rom_pkg::*;
#(
    parameter int                     NSLOT       = 4,
    parameter logic [16*FIELD_W-1:0]  SLOT_AW     = {16{8'd18}},
    parameter logic [16*FIELD_W-1:0]  SLOT_DW     = {16{8'd8}},
    parameter logic [16*OFFSET_W-1:0] SLOT_OFFSET = '0
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vblank,
    input  logic                    downloading,
    input  logic                    loop_rst,
    input  logic [NSLOT-1:0]        slot_cs,
    input  logic [NSLOT*ADDR_W-1:0] slot_addr,
    output logic [NSLOT-1:0]        slot_ok,
    output logic [NSLOT*DATA_W-1:0] slot_dout,
    output logic                    sdram_req,
    input  logic                    sdram_ack,
    input  logic                    data_rdy,
    output logic [ADDR_W-1:0]       sdram_addr,
    input  logic [DATA_W-1:0]       data_read,
    output logic                    refresh_en
);

    localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    rom_state_e        state_q, state_d;
    logic [SW-1:0]     winner_q, winner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
`ifdef JTFRAME_ROM_RR_EN
    logic [SW-1:0]     last_q, last_d;
`endif

    logic              flush;
    logic              wr_en;
    logic              any_miss;
    logic [SW-1:0]     pick;
    logic [SW-1:0]     idx;
    logic [NSLOT-1:0]  miss_vec;
    logic [NSLOT-1:0]  wr_vec;
    logic [ADDR_W-1:0] fetch_tag  [NSLOT];
    logic [ADDR_W-1:0] fetch_addr [NSLOT];
    logic              unused_vblank;

    assign unused_vblank = vblank;

    // Reset is folded in so outputs sit at their idle values while it is held.
    assign flush    = rst | downloading | loop_rst;
    assign any_miss = |miss_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            assign wr_vec[gi] = wr_en & (winner_q == SW'(gi));

            jtframe_rom_slot #(
                .AW     (int'(SLOT_AW[gi*FIELD_W +: FIELD_W])),
                .DW     (int'(SLOT_DW[gi*FIELD_W +: FIELD_W])),
                .OFFSET (SLOT_OFFSET[gi*OFFSET_W +: OFFSET_W])
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .cs         (slot_cs[gi]),
                .addr       (slot_addr[gi*ADDR_W +: ADDR_W]),
                .wr         (wr_vec[gi]),
                .wr_tag     (tag_q),
                .wr_data    (data_read),
                .ok         (slot_ok[gi]),
                .miss       (miss_vec[gi]),
                .dout       (slot_dout[gi*DATA_W +: DATA_W]),
                .fetch_tag  (fetch_tag[gi]),
                .fetch_addr (fetch_addr[gi])
            );
        end
    endgenerate

    // Descending scan so the candidate closest to the search start wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NSLOT - 1; k >= 0; k--) begin
`ifdef JTFRAME_ROM_RR_EN
            idx = SW'((int'(last_q) + 1 + k) % NSLOT);
`else
            idx = SW'(k);
`endif
            if (miss_vec[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        tag_d    = tag_q;
        wr_en    = 1'b0;
`ifdef JTFRAME_ROM_RR_EN
        last_d   = last_q;
`endif
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_miss) begin
                        winner_d = pick;
                        addr_d   = fetch_addr[pick];
                        tag_d    = fetch_tag[pick];
                        state_d  = ST_REQ;
`ifdef JTFRAME_ROM_RR_EN
                        last_d   = pick;
`endif
                    end
                end
                ST_REQ: begin
                    // A data strobe coinciding with the ack completes the fetch at once.
                    if (sdram_ack) begin
                        if (data_rdy) begin
                            wr_en   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        wr_en   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            addr_q   <= '0;
            tag_q    <= '0;
`ifdef JTFRAME_ROM_RR_EN
            last_q   <= SW'(NSLOT - 1);
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
`ifdef JTFRAME_ROM_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign sdram_req  = (state_q == ST_REQ) & ~flush;
    assign sdram_addr = addr_q;
    assign refresh_en = flush | ((state_q == ST_IDLE) & ~any_miss);

endmodule

// File: tb/tb_jtframe_rom_nslot.sv
// Self-checking bench for jtframe_rom_nslot: directed cycle table, corner-case
// sequences and a randomized single-client phase against a cache model.
module tb_jtframe_rom_nslot;

    localparam int NSLOT = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                vblank = 1'b0;
    logic                downloading = 1'b0;
    logic                loop_rst = 1'b0;
    logic [NSLOT-1:0]    slot_cs = '0;
    logic [NSLOT*22-1:0] slot_addr = '0;
    logic [NSLOT-1:0]    slot_ok;
    logic [NSLOT*32-1:0] slot_dout;
    logic                sdram_req;
    logic                sdram_ack = 1'b0;
    logic                data_rdy = 1'b0;
    logic [21:0]         sdram_addr;
    logic [31:0]         data_read = '0;
    logic                refresh_en;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jtframe_rom_nslot #(
        .NSLOT       (NSLOT),
        .SLOT_AW     ({16{8'd18}}),
        .SLOT_DW     ({{14{8'd8}}, 8'd16, 8'd8}),
        .SLOT_OFFSET ({{14{22'd0}}, 22'h14000, 22'h0})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vblank      (vblank),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .sdram_addr  (sdram_addr),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    typedef struct {
        logic        cs0;
        logic [21:0] a0;
        logic        ack;
        logic        rdy;
        logic [31:0] data;
        logic        e_req;
        logic [21:0] e_addr;
        logic        e_ok;
        logic [31:0] e_dout;
        logic        e_ref;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic cs, input logic [21:0] a);
        slot_cs[s] = cs;
        slot_addr[s*22 +: 22] = a;
    endtask

    function automatic logic okf(input int s);
        return slot_ok[s];
    endfunction

    function automatic logic [31:0] doutf(input int s);
        return slot_dout[s*32 +: 32];
    endfunction

    // Reference: slot0 is 8-bit wide, slot1 16-bit at word offset 0x14000, both AW=18.
    function automatic logic [21:0] m_tag(input int s, input logic [21:0] a);
        int w;
        w = int'(a) % (1 << 18);
        return 22'(w / ((s == 0) ? 4 : 2));
    endfunction

    function automatic logic [21:0] m_fetch(input int s, input logic [21:0] a);
        int off;
        off = (s == 0) ? 0 : 32'h14000;
        return 22'((off + 2 * int'(m_tag(s, a))) % (1 << 22));
    endfunction

    function automatic logic [31:0] m_lane(input int s, input logic [31:0] w, input logic [21:0] a);
        if (s == 0) return (w >> (8 * (int'(a) % 4))) & 32'hFF;
        return (w >> (16 * (int'(a) % 2))) & 32'hFFFF;
    endfunction

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_req"}, 32'(sdram_req), 32'd1);
    endtask

    task automatic serve(input string nm, input logic [21:0] ea, input logic [31:0] d, input bit same);
        #1;
        wait_req(nm);
        check({nm, "_addr"}, 32'(sdram_addr), 32'(ea));
        repeat ($urandom_range(0, 2)) tick();
        sdram_ack = 1'b1;
        if (same) begin
            data_rdy  = 1'b1;
            data_read = d;
        end
        tick();
        sdram_ack = 1'b0;
        if (!same) begin
            repeat ($urandom_range(0, 2)) tick();
            data_rdy  = 1'b1;
            data_read = d;
            tick();
        end
        data_rdy  = 1'b0;
        data_read = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] a;
        logic [21:0] tg;
        logic [31:0] d;
        logic        hit;
        int          w;
        int          s;
        logic        mvalid [2];
        logic [21:0] mtag   [2];
        logic [31:0] mdata  [2];

        //           cs    a0      ack   rdy   data           req   addr    ok    dout    ref
        tbl[0]  = '{1'b1, 22'h5, 1'b0, 1'b0, 32'h0,        1'b0, 22'h0, 1'b0, 32'h0,  1'b0};
        tbl[1]  = '{1'b1, 22'h5, 1'b1, 1'b0, 32'h0,        1'b1, 22'h2, 1'b0, 32'h0,  1'b0};
        tbl[2]  = '{1'b1, 22'h5, 1'b0, 1'b1, 32'hDDCCBBAA, 1'b0, 22'h2, 1'b0, 32'h0,  1'b0};
        tbl[3]  = '{1'b1, 22'h5, 1'b0, 1'b0, 32'h0,        1'b0, 22'h2, 1'b1, 32'hBB, 1'b1};
        tbl[4]  = '{1'b1, 22'h6, 1'b0, 1'b0, 32'h0,        1'b0, 22'h2, 1'b1, 32'hCC, 1'b1};
        tbl[5]  = '{1'b1, 22'h6, 1'b0, 1'b0, 32'h0,        1'b0, 22'h2, 1'b1, 32'hCC, 1'b1};
        tbl[6]  = '{1'b1, 22'h4, 1'b0, 1'b0, 32'h0,        1'b0, 22'h2, 1'b1, 32'hAA, 1'b1};
        tbl[7]  = '{1'b1, 22'h8, 1'b0, 1'b0, 32'h0,        1'b0, 22'h2, 1'b0, 32'h0,  1'b0};
        tbl[8]  = '{1'b1, 22'h7, 1'b0, 1'b0, 32'h0,        1'b1, 22'h4, 1'b1, 32'hDD, 1'b0};
        tbl[9]  = '{1'b1, 22'h7, 1'b1, 1'b0, 32'h0,        1'b1, 22'h4, 1'b1, 32'hDD, 1'b0};
        tbl[10] = '{1'b1, 22'h7, 1'b0, 1'b1, 32'h44332211, 1'b0, 22'h4, 1'b1, 32'hDD, 1'b0};
        tbl[11] = '{1'b1, 22'h7, 1'b0, 1'b0, 32'h0,        1'b0, 22'h4, 1'b0, 32'h0,  1'b0};
        tbl[12] = '{1'b1, 22'h8, 1'b0, 1'b0, 32'h0,        1'b1, 22'h2, 1'b1, 32'h11, 1'b0};
        tbl[13] = '{1'b1, 22'h8, 1'b1, 1'b1, 32'hDDCCBBAA, 1'b1, 22'h2, 1'b1, 32'h11, 1'b0};
        tbl[14] = '{1'b1, 22'h5, 1'b0, 1'b0, 32'h0,        1'b0, 22'h2, 1'b1, 32'hBB, 1'b1};

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_ok", 32'(slot_ok), 32'd0);
        check("rst_dout0", doutf(0), 32'd0);
        check("rst_dout1", doutf(1), 32'd0);
        check("rst_refresh", 32'(refresh_en), 32'd1);

        // Cycle table on slot0: miss, hit, winner address change, same-cycle ack+data
        for (int i = 0; i < 15; i++) begin
            slot_cs[0]       = tbl[i].cs0;
            slot_addr[21:0]  = tbl[i].a0;
            sdram_ack        = tbl[i].ack;
            data_rdy         = tbl[i].rdy;
            data_read        = tbl[i].data;
            #1;
            check($sformatf("t%0d_req", i), 32'(sdram_req), 32'(tbl[i].e_req));
            check($sformatf("t%0d_addr", i), 32'(sdram_addr), 32'(tbl[i].e_addr));
            check($sformatf("t%0d_ok", i), 32'(okf(0)), 32'(tbl[i].e_ok));
            check($sformatf("t%0d_refresh", i), 32'(refresh_en), 32'(tbl[i].e_ref));
            if (tbl[i].e_ok) check($sformatf("t%0d_dout", i), doutf(0), tbl[i].e_dout);
            tick();
        end
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;

        // Slot1, 16-bit client with offset
        set_slot(1, 1'b1, 22'h3);
        #1;
        check("s1_miss_ok", 32'(okf(1)), 32'd0);
        serve("s1", 22'h14002, 32'h12345678, 1'b0);
        #1;
        check("s1_ok", 32'(okf(1)), 32'd1);
        check("s1_dout", doutf(1), 32'h1234);
        check("s1_s0_ok", 32'(okf(0)), 32'd1);

        // Contention: new tags for both each round; loser is retargeted before it is served.
        // The last winner so far is slot1, so round-robin starts its search at slot0.
        for (int r = 0; r < 4; r++) begin
            a = 22'(64 * (r + 1));
            set_slot(0, 1'b1, a);
            set_slot(1, 1'b1, a);
`ifdef JTFRAME_ROM_RR_EN
            w = r % 2;
`else
            w = 0;
`endif
            d = $urandom;
            serve($sformatf("arb%0d", r), m_fetch(w, a), d, 1'b0);
            #1;
            check($sformatf("arb%0d_win_ok", r), 32'(okf(w)), 32'd1);
            check($sformatf("arb%0d_lose_ok", r), 32'(okf(1 - w)), 32'd0);
            check($sformatf("arb%0d_dout", r), doutf(w), m_lane(w, d, a));
        end
        set_slot(0, 1'b0, 22'h0);
        set_slot(1, 1'b0, 22'h0);
        tick();

        // Download pulse in WAIT
        set_slot(0, 1'b1, 22'h20);
        serve("dl_pre", 22'h10, 32'h01020304, 1'b0);
        #1;
        check("dl_pre_ok", 32'(okf(0)), 32'd1);
        set_slot(0, 1'b1, 22'h24);
        #1;
        wait_req("dl");
        check("dl_addr", 32'(sdram_addr), 32'h12);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_slot(0, 1'b1, 22'h20);
        downloading = 1'b1;
        #1;
        check("dl_ok", 32'(slot_ok), 32'd0);
        check("dl_req", 32'(sdram_req), 32'd0);
        check("dl_refresh", 32'(refresh_en), 32'd1);
        tick();
        downloading = 1'b0;
        data_rdy    = 1'b1;
        data_read   = 32'hDEADBEEF;
        tick();
        data_rdy  = 1'b0;
        data_read = '0;
        check("dl_stray_ok", 32'(okf(0)), 32'd0);
        check("dl_refetch_req", 32'(sdram_req), 32'd1);
        serve("dl_fresh", 22'h10, 32'hA1B2C3D4, 1'b0);
        #1;
        check("dl_fresh_ok", 32'(okf(0)), 32'd1);
        check("dl_fresh_dout", doutf(0), 32'hD4);

        // Reset while in REQ
        set_slot(0, 1'b1, 22'h30);
        #1;
        wait_req("rr");
        rst = 1'b1;
        tick();
        check("rreq_req", 32'(sdram_req), 32'd0);
        check("rreq_refresh", 32'(refresh_en), 32'd1);
        check("rreq_addr", 32'(sdram_addr), 32'd0);
        check("rreq_ok", 32'(slot_ok), 32'd0);
        check("rreq_dout0", doutf(0), 32'd0);
        check("rreq_dout1", doutf(1), 32'd0);
        rst = 1'b0;
        slot_cs = '0;
        tick();
        data_rdy  = 1'b1;
        data_read = 32'hBADC0FFE;
        tick();
        data_rdy  = 1'b0;
        data_read = '0;
        set_slot(0, 1'b1, 22'h30);
        #1;
        check("rreq_stray_ok", 32'(okf(0)), 32'd0);
        serve("rreq_fresh", 22'h18, 32'h55667788, 1'b1);
        #1;
        check("rreq_fresh_ok", 32'(okf(0)), 32'd1);
        check("rreq_fresh_dout", doutf(0), 32'h88);

        // Randomized single-client traffic against the cache model
        mvalid[0] = 1'b1; mtag[0] = m_tag(0, 22'h30); mdata[0] = 32'h55667788;
        mvalid[1] = 1'b0; mtag[1] = '0;               mdata[1] = '0;
        for (int t = 0; t < 80; t++) begin
            s = int'($urandom_range(0, 1));
            a = 22'(($urandom_range(0, 15) << 18) | $urandom_range(0, 23));
            vblank  = 1'($urandom_range(0, 1));
            slot_cs = '0;
            set_slot(s, 1'b1, a);
            #1;
            tg  = m_tag(s, a);
            hit = mvalid[s] && (mtag[s] == tg);
            check($sformatf("rnd%0d_ok", t), 32'(okf(s)), 32'(hit));
            check($sformatf("rnd%0d_idle_ok", t), 32'(okf(1 - s)), 32'd0);
            if (hit) begin
                check($sformatf("rnd%0d_dout", t), doutf(s), m_lane(s, mdata[s], a));
                tick();
                check($sformatf("rnd%0d_noreq", t), 32'(sdram_req), 32'd0);
            end else begin
                d = $urandom;
                serve($sformatf("rnd%0d", t), m_fetch(s, a), d, ($urandom_range(0, 3) == 0));
                mvalid[s] = 1'b1;
                mtag[s]   = tg;
                mdata[s]  = d;
                #1;
                check($sformatf("rnd%0d_fill_ok", t), 32'(okf(s)), 32'd1);
                check($sformatf("rnd%0d_fill_dout", t), doutf(s), m_lane(s, d, a));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
